// File: rtl/program_memory_loader.sv
// -----------------------------------------------------------------------------
// program_memory_loader
//
// Instruction RAM with a byte-stream boot loader and a registered fetch port.
// The boot stream comes from the UART receiver. It starts with a 4-byte
// little-endian word count L, followed by L little-endian instruction words.
//
// Byte handshake: a byte is transferred on a rising clk edge when rx_valid and
// rx_ready are both high. rx_ready is registered and depends only on the
// loader state (high in HEADER and PAYLOAD). The receiver may hold rx_valid
// for any number of cycles. Bytes offered while rx_ready is low are dropped.
//
// Ports:
//   clk, reset_n      clock (posedge) and asynchronous active-low reset
//   load_start        one-cycle pulse; starts a new load, aborting any load
//                     already in progress
//   rx_valid/rx_data  incoming byte stream
//   rx_ready          loader accepts a byte this cycle
//   read_enable       fetch request; ignored while loading
//   read_address      byte address; the word-offset bits are ignored
//   read_data         fetched word (one cycle after the request)
//   read_valid        read_data was refreshed by the previous request
//   loading           loader is in HEADER or PAYLOAD
//   load_done         sticky; the last load completed
//   load_error        sticky; the header length exceeded DEPTH
//   words_loaded      words written by the current or last load
//
// Assumes DEPTH is a power of two >= 2. Read addresses wrap modulo DEPTH.
// The memory array is not reset, so its contents survive reset_n.
// -----------------------------------------------------------------------------
module program_memory_loader #(
  parameter int ADDR_WIDTH = 16,
  parameter int WORD_BYTES = 4,
  parameter int DEPTH      = 2 ** (ADDR_WIDTH - $clog2(WORD_BYTES))
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      load_start,
  input  logic                      rx_valid,
  input  logic [7:0]                rx_data,
  output logic                      rx_ready,
  input  logic                      read_enable,
  input  logic [ADDR_WIDTH-1:0]     read_address,
  output logic [8*WORD_BYTES-1:0]   read_data,
  output logic                      read_valid,
  output logic                      loading,
  output logic                      load_done,
  output logic                      load_error,
  output logic [31:0]               words_loaded
);

  localparam int DATA_WIDTH = 8 * WORD_BYTES;
  localparam int WB_LOG2    = $clog2(WORD_BYTES);
  localparam int MEM_AW     = $clog2(DEPTH);
  // The byte counter also walks the 4 header bytes, so it needs at least 2 bits.
  localparam int CNT_W      = (WB_LOG2 > 2) ? WB_LOG2 : 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_PAYLOAD,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                 state;
  logic [CNT_W-1:0]       byte_cnt;
  logic [31:0]            length;
  logic [DATA_WIDTH-1:0]  word_shift;

  logic [DATA_WIDTH-1:0]  mem [DEPTH];

  logic                   byte_fire;
  logic                   last_word_byte;
  logic                   mem_we;
  logic [31:0]            length_full;
  logic [DATA_WIDTH-1:0]  word_full;
  logic [31:0]            words_next;
  logic [MEM_AW-1:0]      rd_idx;
  logic [MEM_AW-1:0]      wr_idx;
  logic                   unused_addr_bits;

  assign byte_fire      = rx_valid && rx_ready;
  assign last_word_byte = (byte_cnt == CNT_W'(WORD_BYTES - 1));
  assign words_next     = words_loaded + 32'd1;

  // load_start takes priority over a final payload byte arriving in the same
  // cycle, so that byte's word is never written.
  assign mem_we = (state == S_PAYLOAD) && byte_fire && last_word_byte && !load_start;

  assign rd_idx = read_address[WB_LOG2 +: MEM_AW];
  assign wr_idx = words_loaded[MEM_AW-1:0];

  // Word-offset bits (and any bits above the array) take no part in the read.
  assign unused_addr_bits = ^read_address;

  // The current byte lands in the slot selected by byte_cnt. This gives
  // little-endian assembly: the first byte received is the least significant.
  always_comb begin
    length_full = length;
    length_full[8*byte_cnt[1:0] +: 8] = rx_data;
    word_full = word_shift;
    word_full[8*byte_cnt +: 8] = rx_data;
  end

  // Loader FSM. Status outputs are registered next to the state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      rx_ready     <= 1'b0;
      loading      <= 1'b0;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
      words_loaded <= '0;
      byte_cnt     <= '0;
      length       <= '0;
      word_shift   <= '0;
    end else if (load_start) begin
      state        <= S_HEADER;
      rx_ready     <= 1'b1;
      loading      <= 1'b1;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
      words_loaded <= '0;
      byte_cnt     <= '0;
      length       <= '0;
    end else begin
      case (state)
        S_HEADER: begin
          if (byte_fire) begin
            length <= length_full;
            if (byte_cnt == CNT_W'(3)) begin
              byte_cnt <= '0;
              if (length_full == 32'd0) begin
                state     <= S_DONE;
                rx_ready  <= 1'b0;
                loading   <= 1'b0;
                load_done <= 1'b1;
              end else if ({1'b0, length_full} > 33'(DEPTH)) begin
                state      <= S_ERROR;
                rx_ready   <= 1'b0;
                loading    <= 1'b0;
                load_error <= 1'b1;
              end else begin
                state <= S_PAYLOAD;
              end
            end else begin
              byte_cnt <= byte_cnt + CNT_W'(1);
            end
          end
        end
        S_PAYLOAD: begin
          if (byte_fire) begin
            word_shift <= word_full;
            if (last_word_byte) begin
              byte_cnt     <= '0;
              words_loaded <= words_next;
              if (words_next == length) begin
                state     <= S_DONE;
                rx_ready  <= 1'b0;
                loading   <= 1'b0;
                load_done <= 1'b1;
              end
            end else begin
              byte_cnt <= byte_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          // IDLE, DONE and ERROR wait for load_start; rx_ready is already low.
        end
      endcase
    end
  end

  // Instruction array: write-only from the loader and never reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_idx] <= word_full;
    end
  end

  // Fetch port: one-cycle latency. read_data holds when no read is served.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      read_valid <= 1'b0;
      read_data  <= '0;
    end else if (read_enable && !loading) begin
      read_valid <= 1'b1;
      read_data  <= mem[rd_idx];
    end else begin
      read_valid <= 1'b0;
    end
  end

endmodule

// File: doc/program_memory_loader.md
Name: program_memory_loader

Overview:
Parametrised successor to the single-port program memory. It adds a byte-stream boot loader FSM that fills the instruction RAM from a serial receiver: a 4-byte length header, then little-endian words. It also adds a registered read port with a valid flag for the fetch stage. The block sits between the UART receiver and instruction fetch.

Parameters:
ADDR_WIDTH, 16, byte-address width of read_address.
WORD_BYTES, 4, bytes per instruction word; must be a power of two ≥ 1; DATA_WIDTH = 8*WORD_BYTES.
DEPTH, 2**(ADDR_WIDTH - $clog2(WORD_BYTES)), number of words in the array.

Ports:
clk  input  1  system clock, all logic on posedge.
reset_n  input  1  asynchronous active-low reset.
load_start  input  1  single-cycle pulse; begins (or restarts) a load.
rx_valid  input  1  receiver byte valid.
rx_data  input  8  receiver byte.
rx_ready  output  1  loader accepts a byte this cycle.
read_enable  input  1  fetch request.
read_address  input  ADDR_WIDTH  byte address; low $clog2(WORD_BYTES) bits ignored.
read_data  output  DATA_WIDTH  fetched word.
read_valid  output  1  read_data valid this cycle.
loading  output  1  high in HEADER or PAYLOAD.
load_done  output  1  sticky; set on successful load completion.
load_error  output  1  sticky; set when header length > DEPTH.
words_loaded  output  32  count of words written in the current or last load.

Behaviour:
- Reset (async, reset_n low): FSM=IDLE, all outputs 0, byte/word counters 0. Memory array is not reset; contents are retained across reset.
- FSM states: IDLE, HEADER, PAYLOAD, DONE, ERROR.
- Any state, load_start=1 → HEADER next cycle. Clears load_done, load_error, words_loaded and byte counter. A load in progress is aborted; words already written stay in memory.
- HEADER: rx_ready=1. A byte is accepted when rx_valid && rx_ready. Four bytes assemble a 32-bit length L, little-endian (first byte = bits 7:0).
  - After the 4th byte: L==0 → DONE; L>DEPTH → ERROR; else → PAYLOAD.
- PAYLOAD: rx_ready=1. Bytes assemble a word, little-endian.
  - On the WORD_BYTES-th byte, the word is written to index words_loaded in that same clock edge, and words_loaded increments.
  - When words_loaded reaches L: → DONE, rx_ready drops the following cycle.
- DONE: load_done=1, rx_ready=0. Stays until load_start.
- ERROR: load_error=1, rx_ready=0, no writes. Stays until load_start.
- IDLE/DONE/ERROR: rx bytes ignored (rx_ready=0).
- Read port:
  - read_enable=1 with loading=0 → read_data = mem[read_address >> log2(WORD_BYTES)] and read_valid=1 on the next cycle (latency 1).
  - read_enable=0 → read_valid=0 next cycle; read_data holds its last value.
- Read while loading=1: request ignored, read_valid=0 next cycle, read_data held.
- Read of the same word written in the same cycle cannot occur, because reads are blocked during load.
- read_address bits above the array range are truncated (wrap-around modulo DEPTH).
- load_start and a final payload byte in the same cycle: load_start wins. The byte's word is not written and the FSM restarts in HEADER.

Test Plan:
- Reset then idle: read_valid=0, rx_ready=0, load_done=0; assert reset_n low mid-PAYLOAD → all outputs 0 asynchronously, FSM IDLE.
- load_start, bytes 02 00 00 00, 78 56 34 12, EF BE AD DE → load_done=1, words_loaded=2; read addr 0 → 0x12345678 one cycle later; read addr 4 → 0xDEADBEEF.
- Header length DEPTH+1 → load_error=1, rx_ready=0, memory word 0 unchanged on readback.
- Header 00 00 00 00 → DONE directly after the 4th byte, words_loaded=0, no write.
- read_enable during PAYLOAD → read_valid=0; read_address 0x0003 after load → same data as 0x0000 (low bits ignored).
- load_start mid-PAYLOAD after 1 of 3 words → restart in HEADER; new 1-word load completes; word 0 holds the new data, word 1 holds the old data.
